// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, raises a request, shifts one
// byte plus odd parity and stop on device clock falls, then samples the device acknowledge.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready for a command byte
// S_INHIBIT   | clock line held low for INHIBIT_CYCLES
// S_REQ       | clock still low, data pulled low (start bit)
// S_BITS      | clock released; data/parity/stop driven on each device fall
// S_ACK       | next device fall samples the acknowledge bit
// S_WAIT_IDLE | waiting for both lines to float high
// S_DONE      | done pulse, back to idle
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       tx_ack_o,
  output logic       tx_err_o,
  output logic       busy_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);

  localparam int unsigned IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LOAD = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_BITS, S_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  // Index 0 is the clock line, index 1 the data line.
  logic [1:0]          sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [1:0][FW-1:0]  fcnt_q, fcnt_d;
  logic                clk_prev_q, clk_prev_d;
  logic                fall;

  state_t              state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic                par_q, par_d;
  logic [3:0]          idx_q, idx_d;
  logic [IW-1:0]       inh_q, inh_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic                ready_q, ready_d, done_q, done_d, ack_q, ack_d, err_q, err_d;
  logic                abort;
  logic [15:0]         frame;

  always_comb begin
    sync1_d    = {ps2_data_i, ps2_clk_i};
    sync2_d    = sync1_q;
    clk_prev_d = filt_q[0];
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = FLT_LOAD;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == '0) filt_d[i] = sync2_q[i];
        else                 fcnt_d[i] = fcnt_q[i] - 1'b1;
      end
    end
  end

  assign fall  = clk_prev_q & ~filt_q[0];
  // Bits above parity read as 1, so idx 9 (stop) releases the data line.
  assign frame = {7'h7f, par_q, byte_q};

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    par_d     = par_q;
    idx_d     = idx_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    ack_d     = ack_q;
    err_d     = err_q;
    abort     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid_i && ready_q) begin
          byte_d    = tx_data_i;
          par_d     = ~^tx_data_i;
          ack_d     = 1'b0;
          err_d     = 1'b0;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          inh_d     = INH_LOAD;
          ready_d   = 1'b0;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == '0) begin
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          inh_d = inh_q - 1'b1;
        end
      end
      S_REQ: begin
        clk_oe_d = 1'b0;
        idx_d    = '0;
        tmo_d    = TMO_LOAD;
        state_d  = S_BITS;
      end
      S_BITS: begin
        if (fall) begin
          data_oe_d = ~frame[idx_q];
          idx_d     = idx_q + 4'd1;
          tmo_d     = TMO_LOAD;
          if (idx_q == 4'd9) state_d = S_ACK;
        end else if (tmo_q == '0) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          ack_d   = ~filt_q[1];
          err_d   = filt_q[1];
          tmo_d   = TMO_LOAD;
          state_d = S_WAIT_IDLE;
        end else if (tmo_q == '0) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q == 2'b11) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (fall) begin
          tmo_d = TMO_LOAD;
        end else if (tmo_q == '0) begin
          abort = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_DONE: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ack_d     = 1'b0;
      err_d     = 1'b1;
      done_d    = 1'b1;
      state_d   = S_DONE;
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      fcnt_q     <= {2{FLT_LOAD}};
      clk_prev_q <= 1'b1;
      state_q    <= S_IDLE;
      byte_q     <= '0;
      par_q      <= 1'b0;
      idx_q      <= '0;
      inh_q      <= '0;
      tmo_q      <= '0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      idx_q      <= idx_d;
      inh_q      <= inh_d;
      tmo_q      <= tmo_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign tx_ready_o    = ready_q;
  assign busy_o        = ~ready_q;
  assign tx_done_o     = done_q;
  assign tx_ack_o      = ack_q;
  assign tx_err_o      = err_q;
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model on open-drain lines checks the
// transmitted frame and acknowledge, plus timeout, glitch and mid-frame reset cases.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 400;
  localparam int FL   = 4;
  localparam int HALF = 60;
  localparam int QTR  = 30;

  logic       clk = 1'b0;
  logic       res_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_ack, tx_err, busy;
  logic       clk_oe, data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       line_clk, line_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  assign line_clk  = dev_clk & ~clk_oe;
  assign line_data = dev_data & ~data_oe;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .FILTER_LEN    (FL)
  ) dut (
    .clk_i        (clk),
    .res_n_i      (res_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .tx_done_o    (tx_done),
    .tx_ack_o     (tx_ack),
    .tx_err_o     (tx_err),
    .busy_o       (busy),
    .ps2_clk_i    (line_clk),
    .ps2_data_i   (line_data),
    .ps2_clk_oe_o (clk_oe),
    .ps2_data_oe_o(data_oe)
  );

  task automatic accept(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (clk_oe === 1'b0 && data_oe === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic device_frame(input logic [7:0] b, input bit nack, input bit glitch,
                              input string nm);
    logic [10:0] got;
    logic [10:0] exp;
    bit          ok;
    bit          seen;
    exp = {1'b1, ~^b, b, 1'b0};
    got = '0;
    wait_release(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s release: line never released (clk_oe=%b data_oe=%b)", nm, clk_oe, data_oe);
      return;
    end
    for (int i = 0; i < 11; i++) begin
      repeat (QTR) @(negedge clk);
      if (glitch && i == 5) begin
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        dev_clk = 1'b1;
      end
      got[i] = line_data;
      if (i == 10 && !nack) dev_data = 1'b0;
      repeat (QTR) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done: no tx_done_o pulse within budget", nm);
      return;
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s frame: got %b expected %b (stop..start)", nm, got, exp);
    end
    checks++;
    if (got[9] !== ~^b) begin
      errors++;
      $display("FAIL %s parity: got %b expected %b", nm, got[9], ~^b);
    end
    checks++;
    if ({tx_ack, tx_err} !== {~nack, nack}) begin
      errors++;
      $display("FAIL %s ack/err: got %b%b expected %b%b", nm, tx_ack, tx_err, ~nack, nack);
    end
    checks++;
    if ({clk_oe, data_oe} !== 2'b00) begin
      errors++;
      $display("FAIL %s oe at done: got %b%b expected 00", nm, clk_oe, data_oe);
    end
    @(negedge clk);
    checks++;
    if ({tx_done, tx_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL %s after done: done/ready/busy got %b%b%b expected 010",
               nm, tx_done, tx_ready, busy);
    end
    checks++;
    if ({tx_ack, tx_err} !== {~nack, nack}) begin
      errors++;
      $display("FAIL %s ack/err hold: got %b%b expected %b%b", nm, tx_ack, tx_err, ~nack, nack);
    end
  endtask

  task automatic test_reset();
    res_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, tx_done, tx_ack, tx_err, clk_oe, data_oe} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset values: got %b expected 1000000",
               {tx_ready, busy, tx_done, tx_ack, tx_err, clk_oe, data_oe});
    end
    res_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_ready, busy, tx_done, tx_ack, tx_err, clk_oe, data_oe} !== 7'b1000000) begin
      errors++;
      $display("FAIL idle after reset: got %b expected 1000000",
               {tx_ready, busy, tx_done, tx_ack, tx_err, clk_oe, data_oe});
    end
  endtask

  task automatic test_basic();
    int n;
    int dhi;
    accept(8'hED);
    checks++;
    if ({busy, tx_ready, clk_oe, data_oe} !== 4'b1010) begin
      errors++;
      $display("FAIL accept outputs: busy/ready/clk_oe/data_oe got %b expected 1010",
               {busy, tx_ready, clk_oe, data_oe});
    end
    n   = 0;
    dhi = 0;
    while (clk_oe === 1'b1 && n < 5000) begin
      n++;
      if (data_oe === 1'b1) dhi++;
      @(negedge clk);
    end
    checks++;
    if (n !== INH + 1) begin
      errors++;
      $display("FAIL inhibit length: got %0d cycles expected %0d", n, INH + 1);
    end
    checks++;
    if (dhi !== 1) begin
      errors++;
      $display("FAIL request cycles: data_oe high %0d cycles with clk_oe expected 1", dhi);
    end
    device_frame(8'hED, 1'b0, 1'b0, "ed");
  endtask

  task automatic test_parity();
    accept(8'h00);
    device_frame(8'h00, 1'b0, 1'b0, "p00");
    accept(8'h01);
    tx_data  = 8'hFE;
    tx_valid = 1'b1;
    device_frame(8'h01, 1'b0, 1'b0, "p01");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL p01 no re-accept: busy got %b expected 0", busy);
    end
    accept(8'hFF);
    device_frame(8'hFF, 1'b0, 1'b0, "pff");
  endtask

  task automatic test_nack();
    accept(8'hA5);
    device_frame(8'hA5, 1'b1, 1'b0, "nack");
  endtask

  task automatic test_timeout();
    bit   ok;
    bit   seen;
    int   n;
    logic prev_doe;
    accept(8'h55);
    wait_release(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tmo release: line never released");
      return;
    end
    n        = 0;
    seen     = 1'b0;
    prev_doe = data_oe;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      n++;
      if (tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      prev_doe = data_oe;
    end
    checks++;
    if (!seen || n !== TMO) begin
      errors++;
      $display("FAIL tmo latency: done seen=%b after %0d cycles expected %0d", seen, n, TMO);
    end
    checks++;
    if ({tx_err, tx_ack, clk_oe, data_oe} !== 4'b1000) begin
      errors++;
      $display("FAIL tmo outputs: err/ack/clk_oe/data_oe got %b expected 1000",
               {tx_err, tx_ack, clk_oe, data_oe});
    end
    checks++;
    if (prev_doe !== 1'b1) begin
      errors++;
      $display("FAIL tmo data_oe before drop: got %b expected 1", prev_doe);
    end
    @(negedge clk);
    checks++;
    if ({tx_done, tx_ready} !== 2'b01) begin
      errors++;
      $display("FAIL tmo after done: done/ready got %b expected 01", {tx_done, tx_ready});
    end
  endtask

  task automatic test_glitch();
    accept(8'h3C);
    device_frame(8'h3C, 1'b0, 1'b1, "glitch");
  endtask

  task automatic test_reset_midframe();
    bit ok;
    int prev_done;
    accept(8'h50);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    wait_release(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst release: line never released");
      tx_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    repeat (QTR) @(negedge clk);
    checks++;
    if (data_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst pre-check: data_oe got %b expected 1 (D3 of 0x50)", data_oe);
    end
    prev_done = done_cnt;
    #3 res_n = 1'b0;
    #1;
    checks++;
    if ({tx_ready, busy, tx_done, clk_oe, data_oe} !== 5'b10000) begin
      errors++;
      $display("FAIL rst async: ready/busy/done/clk_oe/data_oe got %b expected 10000",
               {tx_ready, busy, tx_done, clk_oe, data_oe});
    end
    repeat (4) @(negedge clk);
    res_n = 1'b1;
    #1;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst release ready: got %b expected 1", tx_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done_cnt !== prev_done) begin
      errors++;
      $display("FAIL rst restart: busy got %b expected 1, done pulses %0d expected 0",
               busy, done_cnt - prev_done);
    end
    tx_valid = 1'b0;
    device_frame(8'hFF, 1'b0, 1'b0, "rst_ff");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_nack();
    test_timeout();
    test_glitch();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
